npc_mem_arbiter: RTL and testbench
==================================

Name: npc_mem_arbiter

Overview:
- Shares the core's single memory port between the instruction-fetch unit and the load/store unit.
- Accepts one request at a time through valid/ready handshakes and drives one outstanding transaction on the downstream memory port.
- Returns the response only to the requester that owns the transaction.
- Sits between IFU/LSU and the memory/bus bridge; it replaces the direct per-unit memory accesses as the core becomes multi-cycle.

Parameters:
- RR_MODE, 1: 1 = round-robin between IFU and LSU; 0 = fixed priority, LSU wins.
- TIMEOUT, 255: maximum cycles to wait for mem_resp_valid before returning an error response; 0 disables the timeout.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- ifu_req_valid  in  1  fetch request
- ifu_req_ready  out  1  fetch request accepted this cycle
- ifu_addr  in  32  fetch address
- ifu_resp_valid  out  1  fetch response, one-cycle pulse
- ifu_rdata  out  32  fetched instruction
- ifu_resp_err  out  1  fetch timed out
- lsu_req_valid  in  1  load/store request
- lsu_req_ready  out  1  load/store request accepted this cycle
- lsu_addr  in  32  data address
- lsu_wen  in  1  1 = store
- lsu_wdata  in  32  store data
- lsu_wmask  in  4  store byte mask
- lsu_resp_valid  out  1  load/store response, one-cycle pulse
- lsu_rdata  out  32  load data (0 for stores)
- lsu_resp_err  out  1  load/store timed out
- mem_req_valid  out  1  downstream request
- mem_req_ready  in  1  downstream accepts
- mem_addr  out  32  downstream address
- mem_wen  out  1  downstream write enable
- mem_wdata  out  32  downstream write data
- mem_wmask  out  4  downstream byte mask
- mem_resp_valid  in  1  downstream response
- mem_rdata  in  32  downstream read data
- busy  out  1  high whenever state != IDLE

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on rst.
- FSM states: IDLE, REQ, RESP, DONE.
- IDLE:
  - Grant logic: *_req_ready is combinational and is high only in IDLE, only for the granted requester, and only when that requester's valid is high.
  - On handshake: latch addr/wen/wdata/wmask and owner ID, update last_grant, go to REQ.
  - IFU requests latch wen=0 and wmask=0.
- REQ:
  - mem_req_valid=1, with mem_* driven from the latched registers. Values are stable until mem_req_ready.
  - On mem_req_ready: clear the timeout counter and go to RESP.
- RESP:
  - Wait for mem_resp_valid.
  - On mem_resp_valid: latch rdata (0 if the transaction is a write), err=0, go to DONE.
  - Otherwise increment the timeout counter. When the counter reaches TIMEOUT (TIMEOUT>0): rdata=0, err=1, go to DONE.
- DONE:
  - The owner's resp_valid=1 for exactly one cycle, carrying rdata/err. The non-owner's resp_valid stays 0.
  - Next state is IDLE.
- Arbitration when both requesters are valid in IDLE:
  - RR_MODE=1: grant the requester that is not last_grant.
  - RR_MODE=0: grant LSU.
  - A single valid requester is always granted.
- Latency: accept at cycle N; mem_req_valid at N+1; with ready at N+1 and resp at N+2, resp_valid is at N+3. The minimum is 3 cycles from accept to response. Throughput is one transaction per 4 cycles at best.
- mem_resp_valid outside RESP is ignored, including a late response after a timeout.
- Requester valid signals may drop before acceptance without effect. After acceptance, requester inputs are don't-care.
- Timeout counter width is $clog2(TIMEOUT+1). It saturates and does not wrap.
- Reset, including mid-transaction:
  - state=IDLE and last_grant=IFU, so LSU wins the first RR tie.
  - All resp_valid, err, rdata, mem_req_valid, mem_addr, mem_wen, mem_wdata and mem_wmask are 0. busy=0.
  - Any in-flight transaction is dropped with no response.
- Simultaneous events:
  - mem_req_ready and mem_resp_valid in the same REQ cycle: only the ready is honoured.
  - A new request is never accepted in DONE; the earliest re-accept is in the following IDLE cycle.

Decomposition:
- Package npc_mem_pkg:
  - State enum {IDLE, REQ, RESP, DONE}.
  - Owner enum {OWN_IFU, OWN_LSU}.
  - Constant MEM_ERR_RDATA = 32'h0.
- Sub-module npc_rr_pick: combinational 2-way grant from two valids, last_grant and RR_MODE; outputs a one-hot grant.

Test Plan:
- IFU read alone: ifu_addr=0x80000000, mem_req_ready immediately, mem_rdata=0x00000413 one cycle later -> ifu_resp_valid pulse at accept+3 with rdata=0x00000413, err=0; lsu_resp_valid stays 0.
- LSU store: addr=0x80001000, wdata=0xCAFEBABE, wmask=0xF -> mem_wen=1 and mem fields match; lsu_resp_valid with rdata=0, err=0.
- Contention, RR_MODE=1, both held valid after reset -> grant order LSU, IFU, LSU, IFU. With RR_MODE=0 -> LSU every time while it remains valid.
- Backpressure: hold mem_req_ready=0 for 5 cycles -> mem_req_valid and mem_addr stay constant, both *_req_ready=0, busy=1.
- Timeout, TIMEOUT=4: never assert mem_resp_valid -> owner resp_valid with err=1, rdata=0 after 4 RESP cycles; a late mem_resp_valid in IDLE produces no response.
- Reset asserted in RESP -> next cycle state IDLE, all outputs 0, no resp_valid; a new IFU request is accepted on the first cycle after rst deasserts.

Source files
------------

// File: rtl/npc_mem_arbiter_pkg.sv
// Shared types and constants for the IFU/LSU memory-port arbiter.
package npc_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2,
    DONE = 2'd3
  } state_e;

  typedef enum logic {
    OWN_IFU = 1'b0,
    OWN_LSU = 1'b1
  } owner_e;

  // Read data returned alongside a timeout error.
  localparam logic [31:0] MEM_ERR_RDATA = 32'h0;

  // Stores return zero read data; loads/fetches pass the memory data through.
  function automatic logic [31:0] resp_rdata(input logic wen, input logic [31:0] rdata);
    return wen ? 32'h0 : rdata;
  endfunction

endpackage

// File: rtl/npc_mem_arbiter_if.sv
// Requester (IFU/LSU) and downstream memory handshake bundle for the arbiter.
interface npc_mem_arbiter_if;
  logic        ifu_req_valid;
  logic        ifu_req_ready;
  logic [31:0] ifu_addr;
  logic        ifu_resp_valid;
  logic [31:0] ifu_rdata;
  logic        ifu_resp_err;

  logic        lsu_req_valid;
  logic        lsu_req_ready;
  logic [31:0] lsu_addr;
  logic        lsu_wen;
  logic [31:0] lsu_wdata;
  logic [3:0]  lsu_wmask;
  logic        lsu_resp_valid;
  logic [31:0] lsu_rdata;
  logic        lsu_resp_err;

  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_addr;
  logic        mem_wen;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wmask;
  logic        mem_resp_valid;
  logic [31:0] mem_rdata;

  // Arbiter side: serves the requesters, drives the memory port.
  modport slave (
    input  ifu_req_valid, ifu_addr,
    input  lsu_req_valid, lsu_addr, lsu_wen, lsu_wdata, lsu_wmask,
    input  mem_req_ready, mem_resp_valid, mem_rdata,
    output ifu_req_ready, ifu_resp_valid, ifu_rdata, ifu_resp_err,
    output lsu_req_ready, lsu_resp_valid, lsu_rdata, lsu_resp_err,
    output mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask
  );

  // Environment side: requesters and the memory/bus bridge.
  modport master (
    output ifu_req_valid, ifu_addr,
    output lsu_req_valid, lsu_addr, lsu_wen, lsu_wdata, lsu_wmask,
    output mem_req_ready, mem_resp_valid, mem_rdata,
    input  ifu_req_ready, ifu_resp_valid, ifu_rdata, ifu_resp_err,
    input  lsu_req_ready, lsu_resp_valid, lsu_rdata, lsu_resp_err,
    input  mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask
  );
endinterface

// File: rtl/npc_mem_arbiter_rr_pick.sv
// Two-way grant between IFU and LSU: round-robin or fixed LSU priority.
module npc_rr_pick
  import npc_mem_pkg::*;
#(
  parameter int RR_MODE = 1
) (
  input  logic       ifu_valid,
  input  logic       lsu_valid,
  input  owner_e     last_grant,
  output logic [1:0] grant        // one-hot: bit 0 = IFU, bit 1 = LSU
);

  // On a tie, round-robin hands the port to whoever did not have it last.
  always_comb begin
    grant = 2'b00;
    if (ifu_valid && lsu_valid) begin
      if ((RR_MODE != 0) && (last_grant == OWN_LSU)) grant = 2'b01;
      else                                           grant = 2'b10;
    end else if (ifu_valid) begin
      grant = 2'b01;
    end else if (lsu_valid) begin
      grant = 2'b10;
    end
  end

endmodule

// File: rtl/npc_mem_arbiter.sv
// Shares one memory port between IFU and LSU, one transaction in flight.
module npc_mem_arbiter
  import npc_mem_pkg::*;
#(
  parameter int RR_MODE = 1,
  parameter int TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst,
  npc_mem_arbiter_if.slave bus,
  output logic             busy
);

  // A zero TIMEOUT still needs a legal one-bit counter; it simply never fires.
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_e           state_q, state_d;
  owner_e           owner_q, owner_d;
  owner_e           last_grant_q, last_grant_d;
  logic [31:0]      addr_q, addr_d;
  logic             wen_q, wen_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [3:0]       wmask_q, wmask_d;
  logic [31:0]      rdata_q, rdata_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       grant;
  logic             ifu_done, lsu_done;

  npc_rr_pick #(.RR_MODE(RR_MODE)) u_pick (
    .ifu_valid  (bus.ifu_req_valid),
    .lsu_valid  (bus.lsu_req_valid),
    .last_grant (last_grant_q),
    .grant      (grant)
  );

  // Next-state and transaction-register update for the IDLE/REQ/RESP/DONE cycle.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    addr_d       = addr_q;
    wen_d        = wen_q;
    wdata_d      = wdata_q;
    wmask_d      = wmask_q;
    rdata_d      = rdata_q;
    err_d        = err_q;
    cnt_d        = cnt_q;
    case (state_q)
      IDLE: begin
        if (grant != 2'b00) begin
          owner_d      = grant[1] ? OWN_LSU : OWN_IFU;
          last_grant_d = grant[1] ? OWN_LSU : OWN_IFU;
          addr_d       = grant[1] ? bus.lsu_addr : bus.ifu_addr;
          wen_d        = grant[1] & bus.lsu_wen;
          wdata_d      = grant[1] ? bus.lsu_wdata : 32'h0;
          wmask_d      = grant[1] ? bus.lsu_wmask : 4'h0;
          state_d      = REQ;
        end
      end
      REQ: begin
        // A response arriving together with ready is not ours yet; ignore it.
        if (bus.mem_req_ready) begin
          cnt_d   = '0;
          state_d = RESP;
        end
      end
      RESP: begin
        if (bus.mem_resp_valid) begin
          rdata_d = resp_rdata(wen_q, bus.mem_rdata);
          err_d   = 1'b0;
          state_d = DONE;
        end else begin
          if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
          if ((TIMEOUT > 0) && (cnt_q == TO_LAST)) begin
            rdata_d = MEM_ERR_RDATA;
            err_d   = 1'b1;
            state_d = DONE;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and transaction registers; reset drops any in-flight transaction.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      owner_q      <= OWN_IFU;
      last_grant_q <= OWN_IFU;
      addr_q       <= 32'h0;
      wen_q        <= 1'b0;
      wdata_q      <= 32'h0;
      wmask_q      <= 4'h0;
      rdata_q      <= 32'h0;
      err_q        <= 1'b0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      addr_q       <= addr_d;
      wen_q        <= wen_d;
      wdata_q      <= wdata_d;
      wmask_q      <= wmask_d;
      rdata_q      <= rdata_d;
      err_q        <= err_d;
      cnt_q        <= cnt_d;
    end
  end

  assign ifu_done = (state_q == DONE) && (owner_q == OWN_IFU);
  assign lsu_done = (state_q == DONE) && (owner_q == OWN_LSU);

  assign bus.ifu_req_ready  = (state_q == IDLE) && grant[0];
  assign bus.lsu_req_ready  = (state_q == IDLE) && grant[1];
  assign bus.ifu_resp_valid = ifu_done;
  assign bus.ifu_rdata      = ifu_done ? rdata_q : 32'h0;
  assign bus.ifu_resp_err   = ifu_done & err_q;
  assign bus.lsu_resp_valid = lsu_done;
  assign bus.lsu_rdata      = lsu_done ? rdata_q : 32'h0;
  assign bus.lsu_resp_err   = lsu_done & err_q;
  assign bus.mem_req_valid  = (state_q == REQ);
  assign bus.mem_addr       = addr_q;
  assign bus.mem_wen        = wen_q;
  assign bus.mem_wdata      = wdata_q;
  assign bus.mem_wmask      = wmask_q;
  assign busy               = (state_q != IDLE);

endmodule

// File: tb/tb_npc_mem_arbiter.sv
// Directed bench: round-robin DUT and fixed-priority DUT driven in lockstep.
module tb_npc_mem_arbiter;

  logic clk = 1'b0;
  logic rst;
  logic busy_rr, busy_fp;
  int   checks   = 0;
  int   failures = 0;

  npc_mem_arbiter_if if_rr ();
  npc_mem_arbiter_if if_fp ();

  npc_mem_arbiter #(.RR_MODE(1), .TIMEOUT(4)) dut_rr (
    .clk(clk), .rst(rst), .bus(if_rr), .busy(busy_rr)
  );
  npc_mem_arbiter #(.RR_MODE(0), .TIMEOUT(4)) dut_fp (
    .clk(clk), .rst(rst), .bus(if_fp), .busy(busy_fp)
  );

  assign if_fp.ifu_req_valid  = if_rr.ifu_req_valid;
  assign if_fp.ifu_addr       = if_rr.ifu_addr;
  assign if_fp.lsu_req_valid  = if_rr.lsu_req_valid;
  assign if_fp.lsu_addr       = if_rr.lsu_addr;
  assign if_fp.lsu_wen        = if_rr.lsu_wen;
  assign if_fp.lsu_wdata      = if_rr.lsu_wdata;
  assign if_fp.lsu_wmask      = if_rr.lsu_wmask;
  assign if_fp.mem_req_ready  = if_rr.mem_req_ready;
  assign if_fp.mem_resp_valid = if_rr.mem_resp_valid;
  assign if_fp.mem_rdata      = if_rr.mem_rdata;

  always #5 clk = ~clk;

  typedef struct {
    logic        is_lsu;
    logic [31:0] addr;
    logic        wen;
    logic [31:0] wdata;
    logic [3:0]  wmask;
    logic [31:0] mem_rdata;
    logic [31:0] exp_rdata;
    logic        exp_wen;
    logic [3:0]  exp_wmask;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    if_rr.ifu_req_valid  = 1'b0;
    if_rr.lsu_req_valid  = 1'b0;
    if_rr.mem_req_ready  = 1'b0;
    if_rr.mem_resp_valid = 1'b0;
    if_rr.mem_rdata      = 32'h0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vec_t        v;
    logic [3:0]  exp_seq;
    logic        e;

    //            lsu  addr          wen   wdata         wmask mem_rdata     exp_rdata     ewen  ewmask
    vecs[0] = '{1'b0, 32'h8000_0000, 1'b0, 32'h0,        4'h0, 32'h0000_0413, 32'h0000_0413, 1'b0, 4'h0};
    vecs[1] = '{1'b1, 32'h8000_1000, 1'b1, 32'hCAFE_BABE, 4'hF, 32'h1234_5678, 32'h0,        1'b1, 4'hF};
    vecs[2] = '{1'b1, 32'h8000_2004, 1'b0, 32'h0,        4'h0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, 4'h0};
    vecs[3] = '{1'b0, 32'h8000_0004, 1'b0, 32'h0,        4'h0, 32'h0010_0093, 32'h0010_0093, 1'b0, 4'h0};
    vecs[4] = '{1'b1, 32'h8000_3008, 1'b1, 32'h0000_A5A5, 4'h3, 32'hFFFF_FFFF, 32'h0,        1'b1, 4'h3};

    idle_inputs();
    if_rr.ifu_addr  = 32'h0;
    if_rr.lsu_addr  = 32'h0;
    if_rr.lsu_wen   = 1'b0;
    if_rr.lsu_wdata = 32'h0;
    if_rr.lsu_wmask = 4'h0;
    rst = 1'b1;
    tick();
    tick();

    // Reset state
    chk("rst_busy",       busy_rr, 0);
    chk("rst_mem_valid",  if_rr.mem_req_valid, 0);
    chk("rst_mem_addr",   if_rr.mem_addr, 0);
    chk("rst_mem_wen",    if_rr.mem_wen, 0);
    chk("rst_mem_wdata",  if_rr.mem_wdata, 0);
    chk("rst_mem_wmask",  if_rr.mem_wmask, 0);
    chk("rst_ifu_resp",   if_rr.ifu_resp_valid, 0);
    chk("rst_lsu_resp",   if_rr.lsu_resp_valid, 0);
    chk("rst_ifu_rdata",  if_rr.ifu_rdata, 0);
    chk("rst_lsu_err",    if_rr.lsu_resp_err, 0);
    chk("rst_ifu_ready",  if_rr.ifu_req_ready, 0);
    chk("rst_fp_busy",    busy_fp, 0);
    rst = 1'b0;

    // Single-requester transactions from the table
    for (int i = 0; i < 5; i++) begin
      v = vecs[i];
      if (v.is_lsu) begin
        if_rr.lsu_req_valid = 1'b1;
        if_rr.lsu_addr      = v.addr;
        if_rr.lsu_wen       = v.wen;
        if_rr.lsu_wdata     = v.wdata;
        if_rr.lsu_wmask     = v.wmask;
      end else begin
        if_rr.ifu_req_valid = 1'b1;
        if_rr.ifu_addr      = v.addr;
        if_rr.lsu_wen       = 1'b1;
        if_rr.lsu_wmask     = 4'hF;
      end
      #1;
      chk($sformatf("v%0d_own_ready", i), v.is_lsu ? if_rr.lsu_req_ready : if_rr.ifu_req_ready, 1);
      chk($sformatf("v%0d_oth_ready", i), v.is_lsu ? if_rr.ifu_req_ready : if_rr.lsu_req_ready, 0);
      tick();
      if_rr.ifu_req_valid = 1'b0;
      if_rr.lsu_req_valid = 1'b0;
      if_rr.ifu_addr      = 32'hFFFF_FFFF;
      if_rr.lsu_addr      = 32'hFFFF_FFFF;
      if_rr.lsu_wdata     = 32'h0BAD_0BAD;
      #1;
      chk($sformatf("v%0d_mem_valid", i), if_rr.mem_req_valid, 1);
      chk($sformatf("v%0d_mem_addr", i),  if_rr.mem_addr, v.addr);
      chk($sformatf("v%0d_mem_wen", i),   if_rr.mem_wen, v.exp_wen);
      chk($sformatf("v%0d_mem_wmask", i), if_rr.mem_wmask, v.exp_wmask);
      if (v.is_lsu) chk($sformatf("v%0d_mem_wdata", i), if_rr.mem_wdata, v.wdata);
      chk($sformatf("v%0d_busy", i), busy_rr, 1);
      if_rr.mem_req_ready = 1'b1;
      tick();
      if_rr.mem_req_ready  = 1'b0;
      if_rr.mem_resp_valid = 1'b1;
      if_rr.mem_rdata      = v.mem_rdata;
      #1;
      chk($sformatf("v%0d_mem_valid_resp", i), if_rr.mem_req_valid, 0);
      tick();
      if_rr.mem_resp_valid = 1'b0;
      if_rr.mem_rdata      = 32'h5A5A_5A5A;
      #1;
      chk($sformatf("v%0d_own_resp", i), v.is_lsu ? if_rr.lsu_resp_valid : if_rr.ifu_resp_valid, 1);
      chk($sformatf("v%0d_oth_resp", i), v.is_lsu ? if_rr.ifu_resp_valid : if_rr.lsu_resp_valid, 0);
      chk($sformatf("v%0d_rdata", i),    v.is_lsu ? if_rr.lsu_rdata : if_rr.ifu_rdata, v.exp_rdata);
      chk($sformatf("v%0d_err", i),      v.is_lsu ? if_rr.lsu_resp_err : if_rr.ifu_resp_err, 0);
      tick();
      chk($sformatf("v%0d_resp_once", i), v.is_lsu ? if_rr.lsu_resp_valid : if_rr.ifu_resp_valid, 0);
      chk($sformatf("v%0d_idle", i), busy_rr, 0);
    end

    // Contention: both requesters held valid after reset
    do_reset();
    if_rr.ifu_req_valid = 1'b1;
    if_rr.ifu_addr      = 32'h8000_0100;
    if_rr.lsu_req_valid = 1'b1;
    if_rr.lsu_addr      = 32'h8000_2000;
    if_rr.lsu_wen       = 1'b0;
    exp_seq = 4'b0101;
    for (int k = 0; k < 4; k++) begin
      e = exp_seq[k];
      #1;
      chk($sformatf("rr%0d_lsu_grant", k), if_rr.lsu_req_ready, e);
      chk($sformatf("rr%0d_ifu_grant", k), if_rr.ifu_req_ready, !e);
      chk($sformatf("fp%0d_lsu_grant", k), if_fp.lsu_req_ready, 1);
      chk($sformatf("fp%0d_ifu_grant", k), if_fp.ifu_req_ready, 0);
      tick();
      chk($sformatf("rr%0d_mem_addr", k), if_rr.mem_addr, e ? 32'h8000_2000 : 32'h8000_0100);
      chk($sformatf("fp%0d_mem_addr", k), if_fp.mem_addr, 32'h8000_2000);
      if_rr.mem_req_ready = 1'b1;
      tick();
      if_rr.mem_req_ready  = 1'b0;
      if_rr.mem_resp_valid = 1'b1;
      if_rr.mem_rdata      = 32'h0000_1000 + k;
      tick();
      if_rr.mem_resp_valid = 1'b0;
      chk($sformatf("rr%0d_lsu_resp", k), if_rr.lsu_resp_valid, e);
      chk($sformatf("rr%0d_ifu_resp", k), if_rr.ifu_resp_valid, !e);
      chk($sformatf("rr%0d_done_ready", k), {if_rr.ifu_req_ready, if_rr.lsu_req_ready}, 0);
      chk($sformatf("fp%0d_lsu_rdata", k), if_fp.lsu_rdata, 32'h0000_1000 + k);
      tick();
    end
    if_rr.ifu_req_valid = 1'b0;
    if_rr.lsu_req_valid = 1'b0;
    #1;

    // Backpressure: mem_req_ready low for 5 cycles, other requesters waiting
    if_rr.ifu_req_valid = 1'b1;
    if_rr.ifu_addr      = 32'h8000_0200;
    tick();
    if_rr.ifu_addr      = 32'h1111_1111;
    if_rr.lsu_req_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      #1;
      chk($sformatf("bp%0d_mem_valid", c), if_rr.mem_req_valid, 1);
      chk($sformatf("bp%0d_mem_addr", c),  if_rr.mem_addr, 32'h8000_0200);
      chk($sformatf("bp%0d_readies", c),   {if_rr.ifu_req_ready, if_rr.lsu_req_ready}, 0);
      chk($sformatf("bp%0d_busy", c),      busy_rr, 1);
      tick();
    end
    // Ready and response in the same REQ cycle: only the ready counts
    if_rr.ifu_req_valid  = 1'b0;
    if_rr.lsu_req_valid  = 1'b0;
    if_rr.mem_req_ready  = 1'b1;
    if_rr.mem_resp_valid = 1'b1;
    if_rr.mem_rdata      = 32'hBADB_AD00;
    tick();
    if_rr.mem_req_ready  = 1'b0;
    if_rr.mem_resp_valid = 1'b0;
    #1;
    chk("bp_resp_not_early", if_rr.ifu_resp_valid, 0);
    chk("bp_in_resp_busy",   busy_rr, 1);
    chk("bp_in_resp_mvalid", if_rr.mem_req_valid, 0);
    tick();
    if_rr.mem_resp_valid = 1'b1;
    if_rr.mem_rdata      = 32'h0000_8067;
    tick();
    if_rr.mem_resp_valid = 1'b0;
    chk("bp_resp_valid", if_rr.ifu_resp_valid, 1);
    chk("bp_resp_rdata", if_rr.ifu_rdata, 32'h0000_8067);
    tick();

    // Timeout after 4 silent RESP cycles, then a late response in IDLE
    if_rr.lsu_req_valid = 1'b1;
    if_rr.lsu_addr      = 32'h8000_3000;
    if_rr.lsu_wen       = 1'b0;
    tick();
    if_rr.lsu_req_valid = 1'b0;
    if_rr.mem_req_ready = 1'b1;
    tick();
    if_rr.mem_req_ready = 1'b0;
    for (int c = 0; c < 4; c++) begin
      #1;
      chk($sformatf("to%0d_no_resp", c), if_rr.lsu_resp_valid, 0);
      chk($sformatf("to%0d_busy", c),    busy_rr, 1);
      tick();
    end
    chk("to_resp_valid", if_rr.lsu_resp_valid, 1);
    chk("to_resp_err",   if_rr.lsu_resp_err, 1);
    chk("to_resp_rdata", if_rr.lsu_rdata, 0);
    chk("to_ifu_quiet",  if_rr.ifu_resp_valid, 0);
    chk("to_fp_err",     if_fp.lsu_resp_err, 1);
    tick();
    if_rr.mem_resp_valid = 1'b1;
    if_rr.mem_rdata      = 32'h7777_7777;
    for (int c = 0; c < 2; c++) begin
      #1;
      chk($sformatf("late%0d_lsu_resp", c), if_rr.lsu_resp_valid, 0);
      chk($sformatf("late%0d_ifu_resp", c), if_rr.ifu_resp_valid, 0);
      chk($sformatf("late%0d_busy", c),     busy_rr, 0);
      tick();
    end
    if_rr.mem_resp_valid = 1'b0;

    // Reset while waiting in RESP, then an immediate new fetch
    if_rr.ifu_req_valid = 1'b1;
    if_rr.ifu_addr      = 32'h8000_0300;
    tick();
    if_rr.ifu_req_valid = 1'b0;
    if_rr.mem_req_ready = 1'b1;
    tick();
    if_rr.mem_req_ready  = 1'b0;
    rst                  = 1'b1;
    if_rr.mem_resp_valid = 1'b1;
    if_rr.mem_rdata      = 32'h0000_0099;
    #1;
    chk("mr_busy_before", busy_rr, 1);
    tick();
    rst                  = 1'b0;
    if_rr.mem_resp_valid = 1'b0;
    #1;
    chk("mr_busy",      busy_rr, 0);
    chk("mr_mem_valid", if_rr.mem_req_valid, 0);
    chk("mr_mem_addr",  if_rr.mem_addr, 0);
    chk("mr_mem_wen",   if_rr.mem_wen, 0);
    chk("mr_mem_wdata", if_rr.mem_wdata, 0);
    chk("mr_mem_wmask", if_rr.mem_wmask, 0);
    chk("mr_ifu_resp",  if_rr.ifu_resp_valid, 0);
    chk("mr_ifu_rdata", if_rr.ifu_rdata, 0);
    chk("mr_lsu_resp",  if_rr.lsu_resp_valid, 0);
    if_rr.ifu_req_valid = 1'b1;
    if_rr.ifu_addr      = 32'h8000_0400;
    #1;
    chk("mr_new_ready", if_rr.ifu_req_ready, 1);
    tick();
    if_rr.ifu_req_valid = 1'b0;
    chk("mr_new_mvalid", if_rr.mem_req_valid, 1);
    chk("mr_new_addr",   if_rr.mem_addr, 32'h8000_0400);
    if_rr.mem_req_ready = 1'b1;
    tick();
    if_rr.mem_req_ready  = 1'b0;
    if_rr.mem_resp_valid = 1'b1;
    if_rr.mem_rdata      = 32'h0000_0013;
    tick();
    if_rr.mem_resp_valid = 1'b0;
    chk("mr_new_resp",  if_rr.ifu_resp_valid, 1);
    chk("mr_new_rdata", if_rr.ifu_rdata, 32'h0000_0013);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
